// File: rtl/ysyx_mem_arb.sv
// rtl/ysyx_mem_arb.sv - IF/LS arbiter and single-outstanding sequencer for the shared memory port
`timescale 1ns/1ps

module ysyx_mem_arb #(
  parameter int XLEN         = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [XLEN-1:0]   if_req_addr,
  input  logic              if_flush,
  output logic              if_resp_valid,
  output logic [31:0]       if_resp_data,

  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic [XLEN-1:0]   ls_req_addr,
  input  logic              ls_req_wen,
  input  logic [XLEN-1:0]   ls_req_wdata,
  input  logic [XLEN/8-1:0] ls_req_wmask,
  output logic              ls_resp_valid,
  output logic [XLEN-1:0]   ls_resp_rdata,

  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_req_addr,
  output logic              mem_req_wen,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic [XLEN/8-1:0] mem_req_wmask,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_resp_rdata,

  output logic              busy
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                owner_ls_q, owner_ls_d;
  logic [XLEN-1:0]     addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic [XLEN/8-1:0]   wmask_q, wmask_d;
  logic [XLEN-1:0]     rdata_q, rdata_d;
  logic                drop_q, drop_d;
  logic [SW-1:0]       starve_q, starve_d;

  logic                in_idle;
  logic                starve_full;
  logic                grant_if;
  logic                grant_ls;

  // Arbitration: only in IDLE, and never while reset is held so readies stay low in reset
  always_comb begin
    in_idle     = (state_q == IDLE) & rst;
    starve_full = (starve_q == STARVE_MAX);
    grant_if    = in_idle & if_req_valid & ~if_flush & (~ls_req_valid | starve_full);
    grant_ls    = in_idle & ls_req_valid & ~grant_if;
  end

  // Next-state, request latching, flush-drop tracking and starvation counting
  always_comb begin
    state_d    = state_q;
    owner_ls_d = owner_ls_q;
    addr_d     = addr_q;
    wen_d      = wen_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    rdata_d    = rdata_q;
    drop_d     = drop_q;
    starve_d   = starve_q;

    unique case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (grant_if) begin
          owner_ls_d = 1'b0;
          addr_d     = if_req_addr;
          wen_d      = 1'b0;
          wdata_d    = '0;
          wmask_d    = '0;
          starve_d   = '0;
          state_d    = ISSUE;
        end else if (grant_ls) begin
          owner_ls_d = 1'b1;
          addr_d     = ls_req_addr;
          wen_d      = ls_req_wen;
          wdata_d    = ls_req_wdata;
          wmask_d    = ls_req_wmask;
          state_d    = ISSUE;
          if (!if_req_valid) begin
            starve_d = '0;
          end else if (!starve_full) begin
            starve_d = starve_q + 1'b1;
          end
        end else if (!if_req_valid) begin
          starve_d = '0;
        end
      end
      ISSUE: begin
        if (!owner_ls_q && if_flush) drop_d = 1'b1;
        if (mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (!owner_ls_q && if_flush) drop_d = 1'b1;
        if (mem_resp_valid) begin
          rdata_d = mem_resp_rdata;
          state_d = RESP;
        end
      end
      RESP: begin
        drop_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched-request registers; reset abandons any bus transaction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      owner_ls_q <= 1'b0;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      rdata_q    <= '0;
      drop_q     <= 1'b0;
      starve_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_ls_q <= owner_ls_d;
      addr_q     <= addr_d;
      wen_q      <= wen_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      rdata_q    <= rdata_d;
      drop_q     <= drop_d;
      starve_q   <= starve_d;
    end
  end

  // Output decode: bus fields come straight from the latches, responses routed by owner
  always_comb begin
    if_req_ready  = grant_if;
    ls_req_ready  = grant_ls;
    mem_req_valid = (state_q == ISSUE);
    mem_req_addr  = addr_q;
    mem_req_wen   = wen_q;
    mem_req_wdata = wdata_q;
    mem_req_wmask = wmask_q;
    if_resp_valid = (state_q == RESP) & ~owner_ls_q & ~drop_q & ~if_flush;
    if_resp_data  = addr_q[2] ? rdata_q[63:32] : rdata_q[31:0];
    ls_resp_valid = (state_q == RESP) & owner_ls_q;
    ls_resp_rdata = wen_q ? '0 : rdata_q;
    busy          = (state_q != IDLE);
  end

endmodule

// File: doc/ysyx_mem_arb.md
Name: ysyx_mem_arb

Overview:
- Arbiter and sequencer for the single shared memory port used by instruction fetch (IF) and load/store (LS).
- Grants one requester at a time and issues exactly one outstanding transaction on the memory bus.
- Routes the response back to the owning requester and drops fetch responses squashed by a pipeline flush.
- Sits between the fetch/LSU stages and the memory interface of ysyx_top.

Parameters:
XLEN, 64, data/address width
STARVE_LIMIT, 4, consecutive LS grants made while IF is pending before IF is forced ahead (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low
if_req_valid  input  1  fetch request
if_req_ready  output  1  fetch request accepted
if_req_addr  input  XLEN  fetch address
if_flush  input  1  squash the current and outstanding fetch
if_resp_valid  output  1  fetch data valid, one-cycle pulse
if_resp_data  output  32  instruction word
ls_req_valid  input  1  load/store request
ls_req_ready  output  1  load/store request accepted
ls_req_addr  input  XLEN  data address
ls_req_wen  input  1  1 = store
ls_req_wdata  input  XLEN  store data
ls_req_wmask  input  XLEN/8  byte strobes
ls_resp_valid  output  1  load data or store ack, one-cycle pulse
ls_resp_rdata  output  XLEN  load data (0 for stores)
mem_req_valid  output  1  bus request
mem_req_ready  input  1  bus accepts request
mem_req_addr  output  XLEN  latched address
mem_req_wen  output  1  latched write enable
mem_req_wdata  output  XLEN  latched write data
mem_req_wmask  output  XLEN/8  latched strobes
mem_resp_valid  input  1  bus response
mem_resp_rdata  input  XLEN  bus read data
busy  output  1  state != IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - All valid/ready outputs, busy and all latched data/address registers go to 0.
  - starve_cnt and drop go to 0.
  - An in-flight bus transaction is abandoned.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - The grant is combinational.
  - grant_if = if_req_valid & !if_flush & (!ls_req_valid | starve_cnt == STARVE_LIMIT).
  - grant_ls = ls_req_valid & !grant_if.
  - The winner's req_ready = 1; the other ready = 0. Both readies are 0 outside IDLE.
  - On a handshake: latch addr/wen/wdata/wmask and owner; go to ISSUE next cycle.
  - IF requests latch wen=0 and wmask=0.
- ISSUE:
  - mem_req_valid = 1 with the latched fields, held stable until mem_req_ready.
  - On mem_req_ready go to WAIT.
  - The request is never retracted, even after a flush.
- WAIT:
  - Wait for mem_resp_valid.
  - On arrival, register the data and go to RESP.
  - mem_resp_valid in any other state is ignored.
- RESP (one cycle):
  - The owner's resp_valid = 1, then go to IDLE.
  - if_resp_data = latched addr[2] ? rdata[63:32] : rdata[31:0].
  - For an LS store, ls_resp_rdata = 0.
  - The non-owner's resp_valid stays 0.
- Latency:
  - Handshake at cycle N; mem_req_valid at N+1.
  - With mem_req_ready at N+1 and mem_resp_valid at N+2, resp_valid is asserted at N+3.
  - The next handshake is possible at N+4.
- Flush:
  - if_flush in IDLE blocks the IF grant that cycle; LS may still be granted.
  - if_flush while owner=IF in ISSUE/WAIT sets drop. The bus transaction completes normally, and in RESP if_resp_valid is suppressed.
  - if_flush during RESP with owner=IF suppresses that cycle's if_resp_valid.
  - drop clears on return to IDLE.
  - if_flush has no effect when owner=LS.
- Starvation counter (saturating, width clog2(STARVE_LIMIT+1)):
  - Increments on an LS grant while if_req_valid=1.
  - Clears on an IF grant, or on any IDLE cycle with if_req_valid=0.
  - Holds in non-IDLE states.
- Simultaneous requests with starve_cnt < STARVE_LIMIT: LS wins.
- Requester fields are sampled only at the handshake; later changes on the inputs are ignored.

Test Plan:
- IF only, addr=0x8000_0004, bus ready immediately, resp 1 cycle later with rdata=0x1111_2222_3333_4444 -> mem_req_valid at N+1; if_resp_valid at N+3 with if_resp_data=0x1111_2222; busy 1 from N+1 to N+3.
- IF and LS both valid in IDLE, starve_cnt=0 -> ls_req_ready=1, if_req_ready=0; LS store wdata=0xDEAD, wmask=0x0F appears on the bus; ls_resp_valid pulses with rdata=0.
- IF held valid, LS valid back-to-back with STARVE_LIMIT=4 -> 4 LS grants, then the 5th arbitration grants IF; starve_cnt returns to 0.
- IF granted, if_flush pulsed during WAIT, bus returns data -> bus handshake completes, if_resp_valid never asserted, FSM returns to IDLE, next request accepted.
- mem_req_ready held 0 for 5 cycles during ISSUE -> mem_req_valid and all fields stable across all 5 cycles; no readies asserted.
- rst driven low asynchronously mid-WAIT -> all outputs 0 immediately; after release, a new IF request completes normally and a stale mem_resp_valid in IDLE is ignored.
